// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus of the
// sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
);
    logic [BIN_W-1:0]    bin;
    logic                start;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                ovf;

    modport master (
        output bin, start,
        input  busy, done, bcd, ovf
    );

    modport slave (
        input  bin, start,
        output busy, done, bcd, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) converter, one
// iteration per clock; result held stable between conversions.
module bin2bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    bin2bcd_seq_if.slave bus
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [63:0] MAXV = 64'(10 ** DIGITS) - 64'd1;
    localparam bit OVF_EN = ((64'd1 << BIN_W) - 64'd1) > MAXV;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [BW-1:0]   scr;
    logic [BIN_W-1:0] shreg;
    logic [CW-1:0]   cnt;
    logic            ovf_f;
    logic            busy_q;
    logic            done_q;
    logic [BW-1:0]   bcd_q;
    logic            ovf_q;
    logic [BW-1:0]   adj;
    logic            ovf_in;

    // Out-of-range detect; tied off when BIN_W cannot exceed it.
    generate
        if (OVF_EN) begin : g_ovf
            assign ovf_in = 64'(bus.bin) > MAXV;
        end else begin : g_no_ovf
            assign ovf_in = 1'b0;
        end
    endgenerate

    // Add 3 to every scratch nibble that is 5 or more.
    always_comb begin
        adj = scr;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
        end
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            scr    <= '0;
            shreg  <= '0;
            cnt    <= '0;
            ovf_f  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg  <= bus.bin;
                        scr    <= '0;
                        cnt    <= '0;
                        ovf_f  <= ovf_in;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scr, shreg} <= {adj, shreg} << 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(BIN_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_q  <= ovf_f ? {DIGITS{4'h9}} : scr;
                    ovf_q  <= ovf_f;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised scoreboard bench for bin2bcd_seq.
// Model predicts acceptance/timing; monitor checks every cycle.
module tb_bin2bcd_seq;
    localparam int BIN_W  = 10;
    localparam int DIGITS = 3;

    logic clk = 1'b0;
    logic rst_n;

    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   exp_q[$];
    int   mb     = 0;
    bit   mdone  = 1'b0;
    bit   rst_q  = 1'b1;
    bit   ending = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference conversion by plain decimal arithmetic.
    function automatic void ref_bcd(input int v,
                                    output logic [11:0] b,
                                    output logic o);
        int t;
        t = v;
        b = '0;
        o = 1'b0;
        if (v > 999) begin
            b = 12'h999;
            o = 1'b1;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                b[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
    endfunction

    // Timing model: a conversion occupies BIN_W+1 busy cycles.
    always @(posedge clk) begin
        rst_q = !rst_n;
        if (!rst_n) begin
            mb    = 0;
            mdone = 1'b0;
        end else begin
            mdone = (mb == 1);
            if (mb != 0)
                mb = mb - 1;
            else if (bus.start) begin
                mb = BIN_W + 1;
                exp_q.push_back(int'(bus.bin));
            end
        end
    end

    // Monitor: pops expected results on done, checks holds.
    logic [11:0] last_bcd = '0;
    logic        last_ovf = 1'b0;
    always @(negedge clk) begin
        logic [11:0] eb;
        logic        eo;
        int          v;
        if (rst_q) begin
            exp_q.delete();
            last_bcd = '0;
            last_ovf = 1'b0;
        end
        checks++;
        if (bus.busy !== (mb != 0)) begin
            errors++;
            $display("FAIL busy got %0b want %0b t=%0t",
                     bus.busy, (mb != 0), $time);
        end
        checks++;
        if (bus.done !== mdone) begin
            errors++;
            $display("FAIL done got %0b want %0b t=%0t",
                     bus.done, mdone, $time);
        end
        if (mdone) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result got %h/%0b want none t=%0t",
                         bus.bcd, bus.ovf, $time);
            end else begin
                v = exp_q.pop_front();
                ref_bcd(v, eb, eo);
                last_bcd = eb;
                last_ovf = eo;
                if (bus.bcd !== eb || bus.ovf !== eo) begin
                    errors++;
                    $display("FAIL result bin=%0d got %h/%0b want %h/%0b",
                             v, bus.bcd, bus.ovf, eb, eo);
                end
            end
        end else begin
            checks++;
            if (bus.bcd !== last_bcd || bus.ovf !== last_ovf) begin
                errors++;
                $display("FAIL hold got %h/%0b want %h/%0b t=%0t",
                         bus.bcd, bus.ovf, last_bcd, last_ovf, $time);
            end
        end
        if (ending) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain got %0d pending want 0",
                         exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic idle_wait();
        for (int i = 0; i < 20 && mb != 0; i++)
            @(negedge clk);
    endtask

    task automatic conv(input int v);
        bus.bin   = 10'(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = 10'($urandom_range(0, 1023));
        idle_wait();
    endtask

    // Stimulus: directed cases, then held start, reset abort, random.
    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        conv(0);
        conv(123);
        conv(999);
        conv(10);
        conv(1000);
        conv(1023);
        conv(5);

        bus.bin   = 10'd456;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.bin   = 10'd789;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        idle_wait();

        bus.start = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            bus.bin = 10'(k);
            @(negedge clk);
            idle_wait();
        end
        bus.start = 1'b0;

        conv(321);
        bus.bin   = 10'd777;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        conv(42);

        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.bin = 10'($urandom_range(990, 1023));
            else
                bus.bin = 10'($urandom_range(0, 1023));
            rst_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (15) @(negedge clk);
        ending = 1'b1;
    end
endmodule
